// File: rtl/dm_access_stage_pkg.sv
// Shared constants for the DM access stage: default widths, timeout limit
// and the 2-bit FSM state encoding used by the top module and the bench.
package dm_access_stage_pkg;

    localparam int DSIZE_DEF = 16;  // datapath width
    localparam int ASIZE_DEF = 4;   // register-file address width
    localparam int MSIZE_DEF = 8;   // data-memory word-address width
    localparam int TMO_DEF   = 15;  // max cycles waiting in REQ or RESP

    typedef logic [1:0] dms_t;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] DMS_IDLE = 2'd0;
    localparam logic [1:0] DMS_REQ  = 2'd1;
    localparam logic [1:0] DMS_RESP = 2'd2;
    localparam logic [1:0] DMS_DONE = 2'd3;

    // True while a memory transaction is outstanding and the timer runs
    function automatic logic dms_waiting(input dms_t s);
        return (s == DMS_REQ) || (s == DMS_RESP);
    endfunction

endpackage

// File: rtl/dm_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag.
// tc rises on the cycle in which the TMO-th waiting cycle is being spent,
// so the owner can leave its wait state on that edge after exactly TMO cycles.
module dm_timeout_ctr #(
    parameter int TMO = 15,
    parameter int CW  = $clog2(TMO + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    // Count waiting cycles; clear has priority, saturate at terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TMO - 1));

endmodule

// File: rtl/dm_access_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/DM
// and DM/WB registers, issues data-memory requests and stalls the upstream
// pipeline while a load or store is outstanding.
//
// Memory handshake:
//   dm_req is registered; while it is high dm_we/dm_addr/dm_wdata are stable.
//   The request is accepted on the rising edge where dm_gnt is sampled high,
//   and dm_req drops on that same edge. A read then returns exactly one
//   dm_rvalid pulse carrying dm_rdata; rvalid is only honoured in RESP.
//   dm_req may also drop without gnt (timeout or reset) and the memory must
//   tolerate the abandoned request.
module dm_access_stage
    import dm_access_stage_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int MSIZE = MSIZE_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             flush_in,
    input  logic             MemRead_in,
    input  logic             MemWrite_in,
    input  logic             MemtoReg_in,
    input  logic             wen_in,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] store_data_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             dm_gnt,
    input  logic             dm_rvalid,
    input  logic [DSIZE-1:0] dm_rdata,
    output logic             dm_req,
    output logic             dm_we,
    output logic [MSIZE-1:0] dm_addr,
    output logic [DSIZE-1:0] dm_wdata,
    output logic             stall_out,
    output logic             err_out,
    output logic [DSIZE-1:0] dm_out,
    output logic [DSIZE-1:0] aluout_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out,
    output logic             MemtoReg_out,
    output logic [1:0]       state_dbg
);

    dms_t             state;
    logic [DSIZE-1:0] rdata_q;
    logic             squash;   // flush seen while waiting: drop the writeback
    logic             tmo_hit;  // current transaction ended by timeout
    logic             memop;
    logic             tmo_tc;
    logic             ctr_clr;
    logic             ctr_en;

    assign memop = valid_in & (MemRead_in | MemWrite_in);

    // Timer restarts on entry to REQ (from IDLE) and on entry to RESP (on gnt)
    assign ctr_clr = (state == DMS_IDLE) || (state == DMS_DONE) ||
                     ((state == DMS_REQ) && dm_gnt);
    assign ctr_en  = dms_waiting(state);

    dm_timeout_ctr #(
        .TMO (TMO)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .tc  (tmo_tc)
    );

    // FSM plus registered request, read data and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DMS_IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            rdata_q  <= '0;
            squash   <= 1'b0;
            tmo_hit  <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            case (state)
                DMS_IDLE: begin
                    // A flushed memop is a bubble: nothing is issued
                    if (memop && !flush_in) begin
                        dm_req   <= 1'b1;
                        dm_we    <= MemWrite_in;
                        dm_addr  <= aluout_in[MSIZE-1:0];
                        dm_wdata <= store_data_in;
                        state    <= DMS_REQ;
                    end
                end
                DMS_REQ: begin
                    // A store cannot be recalled, so a flush only marks the result
                    if (flush_in) begin
                        squash <= 1'b1;
                    end
                    if (dm_gnt) begin
                        dm_req <= 1'b0;
                        state  <= dm_we ? DMS_DONE : DMS_RESP;
                    end else if (tmo_tc) begin
                        dm_req  <= 1'b0;
                        rdata_q <= '0;
                        err_out <= 1'b1;
                        tmo_hit <= 1'b1;
                        state   <= DMS_DONE;
                    end
                end
                DMS_RESP: begin
                    if (flush_in) begin
                        squash <= 1'b1;
                    end
                    if (dm_rvalid) begin
                        rdata_q <= dm_rdata;
                        state   <= DMS_DONE;
                    end else if (tmo_tc) begin
                        rdata_q <= '0;
                        err_out <= 1'b1;
                        tmo_hit <= 1'b1;
                        state   <= DMS_DONE;
                    end
                end
                default: begin
                    // DONE lasts one cycle so a following memop starts fresh
                    squash  <= 1'b0;
                    tmo_hit <= 1'b0;
                    state   <= DMS_IDLE;
                end
            endcase
        end
    end

    // Stall and writeback controls; forced quiet while reset is asserted
    always_comb begin
        stall_out = 1'b0;
        wen_out   = 1'b0;
        dm_out    = '0;
        if (rst) begin
            case (state)
                DMS_IDLE: begin
                    if (memop) begin
                        stall_out = !flush_in;
                    end else begin
                        wen_out = wen_in & valid_in & ~flush_in;
                    end
                end
                DMS_REQ, DMS_RESP: begin
                    stall_out = 1'b1;
                end
                default: begin
                    wen_out = wen_in & ~squash & ~tmo_hit;
                    dm_out  = dm_we ? '0 : rdata_q;
                end
            endcase
        end
    end

    assign aluout_out   = aluout_in;
    assign waddr_out    = waddr_in;
    assign MemtoReg_out = MemtoReg_in;
    assign state_dbg    = state;

endmodule

// File: doc/dm_access_stage.md
Name: dm_access_stage

Overview:
- Memory-access stage between the EX/DM pipeline register and the DM/WB pipeline register of the 5-stage MIPS pipeline.
- Drives data-memory requests over a req/gnt/rvalid handshake and stalls the pipeline while a load or store is outstanding.
- Presents dm data, ALU result, write address, wen and MemtoReg, already squashed as needed, to the DM/WB register inputs.

Parameters:
- DSIZE, 16, datapath width (from define.v).
- ASIZE, 4, register-file address width (from define.v).
- MSIZE, 8, data-memory word-address width; dm_addr = aluout_in[MSIZE-1:0].
- TMO, 15, maximum cycles spent waiting in REQ or RESP before a timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_in  in  1  EX/DM holds a real instruction.
- flush_in  in  1  squash the current instruction.
- MemRead_in  in  1  load.
- MemWrite_in  in  1  store.
- MemtoReg_in  in  1  writeback selects memory data.
- wen_in  in  1  register write enable.
- aluout_in  in  DSIZE  ALU result or effective address.
- store_data_in  in  DSIZE  store data.
- waddr_in  in  ASIZE  destination register.
- dm_gnt  in  1  memory accepted the request.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  DSIZE  read data.
- dm_req  out  1  request, registered.
- dm_we  out  1  1 = write, registered.
- dm_addr  out  MSIZE  address, registered.
- dm_wdata  out  DSIZE  write data, registered.
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/DM; DM/WB captures a bubble.
- err_out  out  1  sticky timeout flag.
- dm_out  out  DSIZE  to DM/WB dm_in.
- aluout_out  out  DSIZE  to DM/WB aluout_in.
- waddr_out  out  ASIZE  to DM/WB waddr_in.
- wen_out  out  1  to DM/WB wen_in.
- MemtoReg_out  out  1  to DM/WB MemtoReg_in.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dm_req, dm_we, dm_addr, dm_wdata, rdata_q, timeout counter, squash flag and err_out all 0.
- Reset values of combinational outputs: stall_out=0, wen_out=0, dm_out=0.
- A reset mid-transaction abandons it; the memory model must tolerate req dropping without gnt.
- memop = valid_in & (MemRead_in | MemWrite_in).
- aluout_out, waddr_out and MemtoReg_out always pass through from inputs.
- IDLE:
  - Non-memop: stall_out=0; wen_out = wen_in & valid_in & ~flush_in; dm_out=0. Zero added latency.
  - memop & flush_in: treated as a bubble, no request issued.
  - memop & ~flush_in: stall_out=1, wen_out=0; latch dm_we=MemWrite_in, dm_addr, dm_wdata; dm_req<=1; go to REQ.
- REQ:
  - stall_out=1, wen_out=0.
  - dm_req is held with address and data stable until dm_gnt.
  - On gnt: dm_req<=0; a write goes to DONE, a read goes to RESP.
  - dm_rvalid is ignored in REQ.
- RESP:
  - stall_out=1, wen_out=0.
  - On dm_rvalid: rdata_q<=dm_rdata; go to DONE.
- DONE:
  - stall_out=0; dm_out=rdata_q (0 for stores); wen_out = wen_in & ~squash.
  - Next state is always IDLE, so a following memop starts a fresh request next cycle.
- Timeout:
  - Counter clears on entry to REQ and on entry to RESP, and increments each cycle spent there.
  - When it reaches TMO: err_out<=1 (sticky until reset), dm_req<=0, rdata_q<=0, go to DONE with wen_out forced 0.
- flush_in during REQ or RESP:
  - Sets the squash flag; the transaction still completes, because a store cannot be recalled.
  - In DONE, wen_out=0. The squash flag clears on return to IDLE.
- Inputs from EX/DM are stable while stall_out=1, because upstream is frozen.
- Minimum stall counts:
  - Load: 3 cycles (IDLE, REQ with gnt, RESP with rvalid), then DONE.
  - Store: 2 cycles, then DONE.
- State encoding: 2 bits. IDLE=0, REQ=1, RESP=2, DONE=3.

Decomposition:
- define.v gains:
  - `MSIZE and `TMO.
  - State encodings `DMS_IDLE, `DMS_REQ, `DMS_RESP, `DMS_DONE.
  - `DSIZE and `ASIZE are reused.
- One sub-module: dm_timeout_ctr, a clear/enable counter with a terminal-count flag.
- The FSM and the request/data registers stay in the top module.

Test Plan:
- ALU op (valid=1, wen=1, aluout=16'h0042, waddr=4'd3) in IDLE -> same cycle wen_out=1, aluout_out=16'h0042, waddr_out=3, stall_out=0.
- Load at aluout=16'h0010, gnt on the 1st REQ cycle, rvalid 2 cycles later with rdata=16'hBEEF -> dm_addr=8'h10, dm_we=0, stall_out high 4 cycles, then DONE: dm_out=16'hBEEF, wen_out=1, MemtoReg_out=1.
- Store of 16'h1234 to addr 8'h20, gnt after 3 REQ cycles -> dm_req held 3 cycles with dm_we=1 and dm_wdata=16'h1234; DONE with wen_out=0; a back-to-back load issues its request the following cycle.
- Load with flush_in pulsed during RESP -> transaction completes; in DONE, wen_out=0; the next instruction writes back normally.
- Load with no rvalid -> after TMO=15 cycles in RESP: err_out=1 (stays set), DONE with wen_out=0 and dm_out=0, then IDLE.
- rst driven low mid-REQ, between clock edges -> dm_req and stall_out drop immediately; state=IDLE and err_out=0 after release.
